// File: rtl/tc_decoder3_rr_sched.sv
// Round-robin owner scheduler driving a shared 3-to-8 decoder (dis, sel0..sel2) plus a one-hot grant mirror.
// Optional forced-release hold timer enabled by defining TC_SCHED_TIMEOUT_EN.
module tc_decoder3_rr_sched #(
  parameter string       NAME     = "",
  parameter int unsigned UUID     = 0,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic       dis,
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic       dis_q, dis_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic       release_s;
  logic       force_s;
  logic [2:0] winner_s;

  // First requester found walking upward from last+1, wrapping 7 -> 0; last itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner_s  = rr_pick(req, last_q);
  assign release_s = done | ~req[sel_q];

`ifdef TC_SCHED_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  // Forced release only when no normal release is due this cycle.
  assign force_s = (hold_q == 8'(HOLD_MAX - 1)) & ~release_s;

  always_comb begin
    hold_d = hold_q;
    if (state_q == S_IDLE) begin
      hold_d = 8'h00;
    end else begin
      hold_d = hold_q + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= 8'h00;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign force_s = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 3'd0;
      last_q    <= 3'd7;
      dis_q     <= 1'b1;
      gnt_q     <= 8'h00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      dis_q     <= dis_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en && (req != 8'h00)) begin
          state_d = S_GRANT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (release_s || force_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GRANT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sel is left untouched on release so the decoder select stays quiet while disabled.
  always_comb begin
    sel_d     = sel_q;
    last_d    = last_q;
    dis_d     = dis_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && (req != 8'h00)) begin
          sel_d  = winner_s;
          dis_d  = 1'b0;
          gnt_d  = 8'h01 << winner_s;
          busy_d = 1'b1;
        end else begin
          dis_d  = 1'b1;
          gnt_d  = 8'h00;
          busy_d = 1'b0;
        end
      end
      S_GRANT: begin
        if (release_s || force_s) begin
          last_d    = sel_q;
          dis_d     = 1'b1;
          gnt_d     = 8'h00;
          busy_d    = 1'b0;
          timeout_d = force_s;
        end else begin
          dis_d  = 1'b0;
          gnt_d  = 8'h01 << sel_q;
          busy_d = 1'b1;
        end
      end
      default: begin
        dis_d  = 1'b1;
        gnt_d  = 8'h00;
        busy_d = 1'b0;
      end
    endcase
  end

  assign dis     = dis_q;
  assign sel0    = sel_q[0];
  assign sel1    = sel_q[1];
  assign sel2    = sel_q[2];
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_tc_decoder3_rr_sched.sv
// Bench for tc_decoder3_rr_sched: vector table plus hand sequences, expectations queued per cycle.
module tb_tc_decoder3_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       done;
  logic       dis;
  logic       sel0, sel1, sel2;
  logic [7:0] gnt;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tc_decoder3_rr_sched #(
    .NAME    ("u_sched"),
    .UUID    (1),
    .HOLD_MAX(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .done   (done),
    .dis    (dis),
    .sel0   (sel0),
    .sel1   (sel1),
    .sel2   (sel2),
    .gnt    (gnt),
    .busy   (busy),
    .timeout(timeout)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic       dis;
    logic [2:0] sel;
    logic       busy;
    logic       to;
    string      name;
  } vec_t;

  typedef struct {
    logic       dis;
    logic [2:0] sel;
    logic       busy;
    logic       to;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic r, input logic e, input logic [7:0] rq, input logic d,
                              input logic x_dis, input logic [2:0] x_sel, input logic x_busy,
                              input logic x_to, input string nm);
    vec_t v;
    v.rst_n = r; v.en = e; v.req = rq; v.done = d;
    v.dis = x_dis; v.sel = x_sel; v.busy = x_busy; v.to = x_to; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string nm, input string field, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%02h exp=%02h", nm, field, got, exp);
    end
  endtask

  task automatic check_out();
    exp_t       e;
    logic [7:0] x_gnt;
    logic [7:0] inv;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard empty got=0 exp=1");
    end else begin
      e     = sb.pop_front();
      x_gnt = e.dis ? 8'h00 : (8'h01 << e.sel);
      cmp(e.name, "dis",     {7'd0, dis},              {7'd0, e.dis});
      cmp(e.name, "sel",     {5'd0, sel2, sel1, sel0}, {5'd0, e.sel});
      cmp(e.name, "gnt",     gnt,                      x_gnt);
      cmp(e.name, "busy",    {7'd0, busy},             {7'd0, e.busy});
      cmp(e.name, "timeout", {7'd0, timeout},          {7'd0, e.to});
      inv = dis ? 8'h00 : (8'h01 << {sel2, sel1, sel0});
      cmp(e.name, "invariant", gnt, inv);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [7:0] rq, input logic d,
                       input logic x_dis, input logic [2:0] x_sel, input logic x_busy,
                       input logic x_to, input string nm);
    exp_t x;
    rst = r; en = e; req = rq; done = d;
    x.dis = x_dis; x.sel = x_sel; x.busy = x_busy; x.to = x_to; x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;

    // Part A: reset and idle with no requests.
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "reset0");
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "reset1");
    for (int i = 0; i < 5; i++)
      add(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "idle_noreq");

    foreach (vecs[i])
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].done,
            vecs[i].dis, vecs[i].sel, vecs[i].busy, vecs[i].to, vecs[i].name);
    vecs.delete();

    // Fairness from reset: all requesting, done one cycle after each grant.
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'(k), 1'b1, 1'b0, "fair_grant");
      drive(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'(k), 1'b0, 1'b0, "fair_gap");
    end

    // Part B: rotation from a given last, joint release, en gating, re-request, reset mid-grant.
    add(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, "set_last4_g");
    add(1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, "set_last4_r");
    add(1'b1, 1'b1, 8'h24, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, "h24_first5");
    add(1'b1, 1'b1, 8'h24, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, "h24_rel5");
    add(1'b1, 1'b1, 8'h24, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "h24_then2");
    add(1'b1, 1'b1, 8'h24, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, "h24_rel2");
    add(1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, "g3");
    add(1'b1, 1'b1, 8'h14, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, "g3_joint_rel");
    add(1'b1, 1'b1, 8'h14, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, "after_joint");
    add(1'b1, 1'b1, 8'h14, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, "rel4");
    add(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "g1");
    add(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "en0_hold_a");
    add(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, "en0_hold_b");
    add(1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, "en0_rel");
    add(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, "en0_idle_a");
    add(1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, "en0_idle_b");
    add(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "en1_g2");
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, "reqdrop_rel");
    add(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, "rereq_alone");
    add(1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, "rereq_rel");
    add(1'b1, 1'b1, 8'h0C, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, "rereq_loses");
    add(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "reset_mid");
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "post_reset");

    foreach (vecs[i])
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].done,
            vecs[i].dis, vecs[i].sel, vecs[i].busy, vecs[i].to, vecs[i].name);

    // Long hold on owner 6 (last=7 after reset): forced release only with the timer built in.
    drive(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, "hold_g6");
`ifdef TC_SCHED_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, "hold_wait");
    drive(1'b1, 1'b1, 8'hC0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, "timeout_rel");
    drive(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, "after_to_g7");
`else
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0, "hold_forever");
    drive(1'b1, 1'b1, 8'hC0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0, "hold_rel");
    drive(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, "after_hold_g7");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
